// File: rtl/cpu_pkg.sv
// Shared CPU definitions: hazard FSM states, the NOP encoding and decode-stage
// operand/load classification used by the hazard unit and the stage units.
package cpu_pkg;

    localparam int unsigned OP_W     = 7;
    localparam int unsigned REG_W    = 4;
    localparam int unsigned HZ_CNT_W = 3;
    localparam int unsigned PERF_W   = 16;

    localparam logic [OP_W-1:0] OPCODE_NOP = 7'b0100000;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        MEM_WAIT   = 2'd3
    } hazard_state_t;

    function automatic logic uses_rn(input logic [OP_W-1:0] op);
        return (!op[6] && (op[3:0] != 4'd0)) || (op[6:5] == 2'b11);
    endfunction

    function automatic logic uses_rm(input logic [OP_W-1:0] op);
        return (!op[6] && op[4]) || ((op[6:5] == 2'b11) && op[3])
            || ((op[6:2] == 5'b10010) && op[0]);
    endfunction

    function automatic logic uses_rs(input logic [OP_W-1:0] op);
        return op[6:4] == 3'b011;
    endfunction

    function automatic logic is_load(input logic [OP_W-1:0] op);
        return ((op[6:5] == 2'b11) && op[2]) || (op[6:4] == 3'b100);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in execute whose destination is a
// source register actually read by the instruction in decode.
module hazard_detect
    import cpu_pkg::*;
(
    input  logic [OP_W-1:0]  opcode_dec_i,
    input  logic [REG_W-1:0] rn_dec_i,
    input  logic [REG_W-1:0] rm_dec_i,
    input  logic [REG_W-1:0] rs_dec_i,
    input  logic [OP_W-1:0]  opcode_ex_i,
    input  logic [REG_W-1:0] rd_ex_i,
    output logic             load_use_c_o
);

    logic both_live;
    logic rn_hit;
    logic rm_hit;
    logic rs_hit;

    // NOPs are masked explicitly so a NOP encoding change cannot create hazards.
    assign both_live = (opcode_dec_i != OPCODE_NOP) && (opcode_ex_i != OPCODE_NOP);
    assign rn_hit    = uses_rn(opcode_dec_i) && (rn_dec_i == rd_ex_i);
    assign rm_hit    = uses_rm(opcode_dec_i) && (rm_dec_i == rd_ex_i);
    assign rs_hit    = uses_rs(opcode_dec_i) && (rs_dec_i == rd_ex_i);

    assign load_use_c_o = both_live && is_load(opcode_ex_i) && (rn_hit || rm_hit || rs_hit);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stalls, memory wait stalls and taken-branch
// flushes. Define HAZARD_PERF_CNT_EN to enable the stall/flush performance counters.
module hazard_unit
    import cpu_pkg::*;
#(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned FLUSH_CYCLES      = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OP_W-1:0]   opcode_decode,
    input  logic [REG_W-1:0]  rn_decode,
    input  logic [REG_W-1:0]  rm_decode,
    input  logic [REG_W-1:0]  rs_decode,
    input  logic [OP_W-1:0]   opcode_execute,
    input  logic [REG_W-1:0]  rd_execute,
    input  logic              branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              stall_fetch,
    output logic              stall_decode,
    output logic              stall_execute,
    output logic              stall_memory,
    output logic              bubble_execute,
    output logic              flush_fetch,
    output logic              flush_decode,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_count
);

    localparam logic [HZ_CNT_W-1:0] FLUSH_CNT = HZ_CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [HZ_CNT_W-1:0] LOAD_CNT  =
        (LOAD_STALL_CYCLES > 1) ? HZ_CNT_W'(LOAD_STALL_CYCLES - 2) : '0;

    hazard_state_t       state_q, state_d;
    logic [HZ_CNT_W-1:0] cnt_q, cnt_d;
    logic                pend_br_q, pend_br_d;

    logic load_use;
    logic mem_wait;
    logic br_run;

    hazard_detect u_detect (
        .opcode_dec_i (opcode_decode),
        .rn_dec_i     (rn_decode),
        .rm_dec_i     (rm_decode),
        .rs_dec_i     (rs_decode),
        .opcode_ex_i  (opcode_execute),
        .rd_ex_i      (rd_execute),
        .load_use_c_o (load_use)
    );

    assign mem_wait = mem_req && !mem_ready;
    assign br_run   = branch_taken || pend_br_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            pend_br_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_br_q <= pend_br_d;
        end
    end

    // Next state; a branch latched during a memory wait is served from RUN.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_br_d = pend_br_q;
        unique case (state_q)
            RUN: begin
                if (br_run) begin
                    state_d   = FLUSH;
                    cnt_d     = FLUSH_CNT;
                    pend_br_d = 1'b0;
                end else if (mem_wait) begin
                    state_d = MEM_WAIT;
                end else if (load_use && (LOAD_STALL_CYCLES > 1)) begin
                    state_d = LOAD_STALL;
                    cnt_d   = LOAD_CNT;
                end
            end
            LOAD_STALL: begin
                if (branch_taken) begin
                    state_d = FLUSH;
                    cnt_d   = FLUSH_CNT;
                end else if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - HZ_CNT_W'(1);
                end
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - HZ_CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                pend_br_d = pend_br_q || branch_taken;
                if (mem_ready) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Mealy outputs; forced low while reset is asserted.
    always_comb begin
        stall_fetch    = 1'b0;
        stall_decode   = 1'b0;
        stall_execute  = 1'b0;
        stall_memory   = 1'b0;
        bubble_execute = 1'b0;
        flush_fetch    = 1'b0;
        flush_decode   = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                RUN: begin
                    if (br_run) begin
                        flush_fetch  = 1'b1;
                        flush_decode = 1'b1;
                    end else if (mem_wait) begin
                        stall_fetch   = 1'b1;
                        stall_decode  = 1'b1;
                        stall_execute = 1'b1;
                        stall_memory  = 1'b1;
                    end else if (load_use) begin
                        stall_fetch    = 1'b1;
                        stall_decode   = 1'b1;
                        bubble_execute = 1'b1;
                    end
                end
                LOAD_STALL: begin
                    if (branch_taken) begin
                        flush_fetch  = 1'b1;
                        flush_decode = 1'b1;
                    end else begin
                        stall_fetch    = 1'b1;
                        stall_decode   = 1'b1;
                        bubble_execute = 1'b1;
                    end
                end
                FLUSH: begin
                    bubble_execute = 1'b1;
                    flush_fetch    = 1'b1;
                    flush_decode   = 1'b1;
                end
                MEM_WAIT: begin
                    if (!mem_ready) begin
                        stall_fetch   = 1'b1;
                        stall_decode  = 1'b1;
                        stall_execute = 1'b1;
                        stall_memory  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cycles_q;
    logic [PERF_W-1:0] flush_count_q;

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (stall_fetch && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + PERF_W'(1);
            end
            if ((state_d == FLUSH) && (state_q != FLUSH) && (flush_count_q != '1)) begin
                flush_count_q <= flush_count_q + PERF_W'(1);
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus random stimulus
// on two parameterisations, compared against a cycle-level behavioural model.
module tb_hazard_unit;

    localparam logic [6:0] NOP_OP = 7'b0100000;
    localparam logic [6:0] LDR_OP = 7'b1100100;
    localparam logic [6:0] ADD_OP = 7'b0000001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode_decode, opcode_execute;
    logic [3:0] rn_decode, rm_decode, rs_decode, rd_execute;
    logic       branch_taken, mem_req, mem_ready;

    logic        sf0, sd0, se0, sm0, bx0, ff0, fd0;
    logic        sf1, sd1, se1, sm1, bx1, ff1, fd1;
    logic [15:0] sc0, fc0, sc1, fc1;
    logic [6:0]  out0, out1;

    int n_total = 0;
    int n_bad   = 0;

    // Model state per instance: remaining flush / load-stall cycles, wait flag, pending branch.
    int lsc_p [2] = '{1, 3};
    int fc_p  [2] = '{2, 3};
    int fl_left [2];
    int ls_left [2];
    bit in_wait [2];
    bit pend    [2];
    int n_stall [2];
    int n_flush [2];

    always #5 clk = ~clk;

    assign out0 = {sf0, sd0, se0, sm0, bx0, ff0, fd0};
    assign out1 = {sf1, sd1, se1, sm1, bx1, ff1, fd1};

    hazard_unit #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .opcode_decode(opcode_decode), .rn_decode(rn_decode), .rm_decode(rm_decode),
        .rs_decode(rs_decode), .opcode_execute(opcode_execute), .rd_execute(rd_execute),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .stall_fetch(sf0), .stall_decode(sd0), .stall_execute(se0), .stall_memory(sm0),
        .bubble_execute(bx0), .flush_fetch(ff0), .flush_decode(fd0),
        .stall_cycles(sc0), .flush_count(fc0)
    );

    hazard_unit #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(3)) dut_long (
        .clk(clk), .rst_n(rst_n),
        .opcode_decode(opcode_decode), .rn_decode(rn_decode), .rm_decode(rm_decode),
        .rs_decode(rs_decode), .opcode_execute(opcode_execute), .rd_execute(rd_execute),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .stall_fetch(sf1), .stall_decode(sd1), .stall_execute(se1), .stall_memory(sm1),
        .bubble_execute(bx1), .flush_fetch(ff1), .flush_decode(fd1),
        .stall_cycles(sc1), .flush_count(fc1)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Decode rules written with integer arithmetic on the opcode value.
    function automatic bit ref_hazard(input logic [6:0] opd, input logic [3:0] rn, rm, rs,
                                      input logic [6:0] ope, input logic [3:0] rd);
        int d = int'(opd);
        int e = int'(ope);
        logic [3:0] srcs[$];
        if (d == 32 || e == 32) return 1'b0;
        if (!(((e / 32) == 3 && ((e / 4) % 2) == 1) || (e / 16) == 4)) return 1'b0;
        if ((d < 64 && (d % 16) != 0) || (d / 32) == 3) srcs.push_back(rn);
        if ((d < 64 && ((d / 16) % 2) == 1) || ((d / 32) == 3 && ((d / 8) % 2) == 1)
            || ((d / 4) == 18 && (d % 2) == 1)) srcs.push_back(rm);
        if ((d / 16) == 3) srcs.push_back(rs);
        foreach (srcs[i]) if (srcs[i] == rd) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int exp_perf(input int n);
`ifdef HAZARD_PERF_CNT_EN
        return (n > 65535) ? 65535 : n;
`else
        return 0 * n;
`endif
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            fl_left[k] = 0; ls_left[k] = 0; in_wait[k] = 1'b0; pend[k] = 1'b0;
            n_stall[k] = 0; n_flush[k] = 0;
        end
    endtask

    // One clock of the model: returns {sf,sd,se,sm,bubble,ff,fd} and advances its state.
    task automatic model_step(input int k, output logic [6:0] exp_o);
        bit hz  = ref_hazard(opcode_decode, rn_decode, rm_decode, rs_decode,
                             opcode_execute, rd_execute);
        bit wt  = mem_req && !mem_ready;
        exp_o = 7'b0;
        if (in_wait[k]) begin
            if (!mem_ready) exp_o = 7'b1111000;
            pend[k] = pend[k] | branch_taken;
            if (mem_ready) in_wait[k] = 1'b0;
        end else if (fl_left[k] > 0) begin
            exp_o = 7'b0000111;
            fl_left[k]--;
        end else if (ls_left[k] > 0) begin
            if (branch_taken) begin
                exp_o = 7'b0000011;
                ls_left[k] = 0;
                fl_left[k] = fc_p[k];
                n_flush[k]++;
            end else begin
                exp_o = 7'b1100100;
                ls_left[k]--;
            end
        end else if (branch_taken || pend[k]) begin
            exp_o = 7'b0000011;
            pend[k] = 1'b0;
            fl_left[k] = fc_p[k];
            n_flush[k]++;
        end else if (wt) begin
            exp_o = 7'b1111000;
            in_wait[k] = 1'b1;
        end else if (hz) begin
            exp_o = 7'b1100100;
            ls_left[k] = lsc_p[k] - 1;
        end
        if (exp_o[6]) n_stall[k]++;
    endtask

    task automatic cycle(input logic [6:0] opd, input logic [3:0] rn, rm, rs,
                         input logic [6:0] ope, input logic [3:0] rd,
                         input logic br, req, rdy);
        logic [6:0] exp_o;
        opcode_decode = opd; rn_decode = rn; rm_decode = rm; rs_decode = rs;
        opcode_execute = ope; rd_execute = rd;
        branch_taken = br; mem_req = req; mem_ready = rdy;
        #4;
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("stall_cycles[%0d]", k), 32'(k == 0 ? sc0 : sc1),
                      32'(exp_perf(n_stall[k])));
            check_val($sformatf("flush_count[%0d]", k), 32'(k == 0 ? fc0 : fc1),
                      32'(exp_perf(n_flush[k])));
            model_step(k, exp_o);
            check_val($sformatf("outputs[%0d]", k), 32'(k == 0 ? out0 : out1), 32'(exp_o));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(NOP_OP, 0, 0, 0, NOP_OP, 0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [6:0] pick_op();
        case ($urandom_range(0, 7))
            0: return NOP_OP;
            1: return LDR_OP;
            2: return 7'b1000011;
            3: return ADD_OP;
            4: return 7'b0010011;
            5: return 7'b0110001;
            6: return 7'b1101011;
            default: return 7'($urandom);
        endcase
    endfunction

    task automatic check_all_zero(input string tag);
        check_val({tag, "_out0"}, 32'(out0), 32'd0);
        check_val({tag, "_out1"}, 32'(out1), 32'd0);
        check_val({tag, "_cnt0"}, {sc0, fc0}, 32'd0);
        check_val({tag, "_cnt1"}, {sc1, fc1}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        opcode_decode = NOP_OP; opcode_execute = NOP_OP;
        rn_decode = 0; rm_decode = 0; rs_decode = 0; rd_execute = 0;
        branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        model_reset();
        #1;
        check_all_zero("reset");
        #11;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load-use on Rn, then the load has moved on.
        cycle(ADD_OP, 3, 5, 6, LDR_OP, 3, 1'b0, 1'b0, 1'b0);
        cycle(ADD_OP, 3, 5, 6, LDR_OP, 3, 1'b0, 1'b0, 1'b0);
        cycle(ADD_OP, 3, 5, 6, NOP_OP, 0, 1'b0, 1'b0, 1'b0);
        idle(3);
        // Different register: no hazard.
        cycle(ADD_OP, 4, 5, 6, LDR_OP, 3, 1'b0, 1'b0, 1'b0);
        // Taken branch.
        cycle(NOP_OP, 0, 0, 0, NOP_OP, 0, 1'b1, 1'b0, 1'b0);
        idle(4);
        // Memory wait for four cycles, then ready.
        for (int i = 0; i < 4; i++) cycle(NOP_OP, 0, 0, 0, NOP_OP, 0, 1'b0, 1'b1, 1'b0);
        cycle(NOP_OP, 0, 0, 0, NOP_OP, 0, 1'b0, 1'b1, 1'b1);
        // Same-cycle request and ready: no stall.
        cycle(NOP_OP, 0, 0, 0, NOP_OP, 0, 1'b0, 1'b1, 1'b1);
        // Ready without request ignored.
        cycle(NOP_OP, 0, 0, 0, NOP_OP, 0, 1'b0, 1'b0, 1'b1);
        // Branch during memory wait is deferred.
        cycle(NOP_OP, 0, 0, 0, NOP_OP, 0, 1'b0, 1'b1, 1'b0);
        cycle(NOP_OP, 0, 0, 0, NOP_OP, 0, 1'b1, 1'b1, 1'b0);
        cycle(NOP_OP, 0, 0, 0, NOP_OP, 0, 1'b0, 1'b1, 1'b0);
        cycle(NOP_OP, 0, 0, 0, NOP_OP, 0, 1'b0, 1'b1, 1'b1);
        idle(4);
        // NOP masking in execute and in decode.
        cycle(ADD_OP, 3, 3, 3, NOP_OP, 3, 1'b0, 1'b0, 1'b0);
        cycle(NOP_OP, 0, 0, 0, LDR_OP, 0, 1'b0, 1'b0, 1'b0);
        // Branch aborting a long load stall.
        cycle(7'b0110001, 2, 2, 2, LDR_OP, 2, 1'b0, 1'b0, 1'b0);
        cycle(7'b0110001, 2, 2, 2, NOP_OP, 0, 1'b1, 1'b0, 1'b0);
        idle(5);
        // Asynchronous reset in the middle of a flush.
        cycle(NOP_OP, 0, 0, 0, NOP_OP, 0, 1'b1, 1'b0, 1'b0);
        branch_taken = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            cycle(pick_op(), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                  4'($urandom_range(0, 3)), pick_op(), 4'($urandom_range(0, 3)),
                  1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
